// File: rtl/store_align_buffer.sv
// store_align_buffer
//   Store alignment buffer between the MEM stage and the data cache. Each
//   SB/SH/SW request is lane-aligned (replicated data + byte enables) and
//   queued in a DEPTH-entry FIFO whose head is presented to the cache.
//   Misaligned SH/SW requests are handshaken but dropped, and flagged by a
//   one-cycle misalign pulse on the following cycle.
//
//   Optional feature: define STORE_MERGE_EN to merge an aligned store into
//   the tail entry when it targets the same word (write combining).
//
// Parameters
//   DEPTH      number of FIFO entries (power of two, 2..16)
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   st_valid   store request from MEM stage
//   st_ready   request accepted when st_valid=1
//   st_type    00 none, 01 SB, 10 SH, 11 SW
//   st_addr    byte address
//   st_data    rs2 value
//   mem_valid  head entry valid (== !empty)
//   mem_ready  cache accepts head entry
//   mem_addr   word address of head entry
//   mem_wdata  lane-aligned write data of head entry
//   mem_be     byte enables of head entry (0000 when empty)
//   misalign   one-cycle pulse after a misaligned store was rejected
//   empty      FIFO holds no entries
module store_align_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        misalign,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];
    localparam logic [PW-1:0] PTR_ONE  = 1;

    function automatic logic [31:0] align_wdata(input logic [1:0] t, input logic [31:0] d);
        case (t)
            2'b01:   return {4{d[7:0]}};
            2'b10:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] align_be(input logic [1:0] t, input logic [1:0] a);
        case (t)
            2'b01:   return 4'b0001 << a;
            2'b10:   return a[1] ? 4'b1100 : 4'b0011;
            2'b11:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] t, input logic [1:0] a);
        return (t == 2'b10 && a[0]) || (t == 2'b11 && a != 2'b00);
    endfunction

    // storage (data only, never reset)
    logic [29:0] addr_q  [DEPTH];
    logic [31:0] wdata_q [DEPTH];
    logic [3:0]  be_q    [DEPTH];

    // control
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count;
    logic          misalign_p1;

    logic        full, bad, accept, enq, deq, can_merge;
    logic [31:0] new_wdata;
    logic [3:0]  new_be;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign bad       = is_misaligned(st_type, st_addr[1:0]);
    assign new_wdata = align_wdata(st_type, st_data);
    assign new_be    = align_be(st_type, st_addr[1:0]);
    assign deq       = !empty && mem_ready;

`ifdef STORE_MERGE_EN
    logic [PW-1:0] tail;
    assign tail = wptr - PTR_ONE;
    // With a single entry the tail is the head; never merge into a leaving head.
    assign can_merge = st_valid && (st_type != 2'b00) && !bad && (count != '0)
                       && (addr_q[tail] == st_addr[31:2])
                       && !((count == CNT_ONE) && deq);
`else
    assign can_merge = 1'b0;
`endif

    assign st_ready = !full || can_merge;
    assign accept   = st_valid && st_ready && (st_type != 2'b00);
    assign enq      = accept && !bad && !can_merge;

    // Stage p0 -> p1: pointer/count update and misalign pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            misalign_p1 <= 1'b0;
        end else begin
            misalign_p1 <= accept && bad;
            if (enq) wptr <= wptr + PTR_ONE;
            if (deq) rptr <= rptr + PTR_ONE;
            case ({enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Stage p0 -> p1: entry storage write (new entry or merge into tail)
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wptr]  <= st_addr[31:2];
            wdata_q[wptr] <= new_wdata;
            be_q[wptr]    <= new_be;
        end
`ifdef STORE_MERGE_EN
        else if (accept && can_merge) begin
            for (int i = 0; i < 4; i++) begin
                if (new_be[i]) wdata_q[tail][8*i +: 8] <= new_wdata[8*i +: 8];
            end
            be_q[tail] <= be_q[tail] | new_be;
        end
`endif
    end

    assign mem_valid = !empty;
    assign mem_addr  = addr_q[rptr];
    assign mem_wdata = wdata_q[rptr];
    assign mem_be    = empty ? 4'b0000 : be_q[rptr];
    assign misalign  = misalign_p1;

endmodule

// File: tb/tb_store_align_buffer.sv
module tb_store_align_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign;
    logic        empty;

    int total = 0;
    int bad   = 0;

    store_align_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
        .st_addr(st_addr), .st_data(st_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .misalign(misalign), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle just after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        st_valid = v;
        st_type  = t;
        st_addr  = a;
        st_data  = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        #3;
        chk("rst_empty",    32'(empty),     32'd1);
        chk("rst_mem_valid",32'(mem_valid), 32'd0);
        chk("rst_st_ready", 32'(st_ready),  32'd1);
        chk("rst_misalign", 32'(misalign),  32'd0);
        chk("rst_mem_be",   32'(mem_be),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // SB to byte lane 3
        drive(1'b1, 2'b01, 32'h0000_1003, 32'h0000_00A5);
        cyc();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("sb_mem_valid", 32'(mem_valid), 32'd1);
        chk("sb_mem_addr",  32'(mem_addr),  32'h400);
        chk("sb_mem_wdata", mem_wdata,      32'hA5A5_A5A5);
        chk("sb_mem_be",    32'(mem_be),    32'b1000);
        chk("sb_empty",     32'(empty),     32'd0);
        cyc();
        chk("sb_hold_wdata", mem_wdata,     32'hA5A5_A5A5);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("sb_drained", 32'(empty), 32'd1);

        // misaligned SH: handshaken, dropped, pulse next cycle
        drive(1'b1, 2'b10, 32'h0000_2001, 32'h0000_BEEF);
        chk("mis_st_ready", 32'(st_ready), 32'd1);
        cyc();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("mis_pulse",     32'(misalign),  32'd1);
        chk("mis_empty",     32'(empty),     32'd1);
        chk("mis_mem_valid", 32'(mem_valid), 32'd0);
        cyc();
        chk("mis_pulse_end", 32'(misalign),  32'd0);

        // aligned SH to upper half, SB to lane 1
        drive(1'b1, 2'b10, 32'h0000_2002, 32'h1234_BEEF);
        cyc();
        drive(1'b1, 2'b01, 32'h0000_3001, 32'h0000_005A);
        chk("sh_wdata", mem_wdata,   32'hBEEF_BEEF);
        chk("sh_be",    32'(mem_be), 32'b1100);
        chk("sh_addr",  32'(mem_addr), 32'h800);
        cyc();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        mem_ready = 1'b1;
        cyc();
        chk("sb1_wdata", mem_wdata,   32'h5A5A_5A5A);
        chk("sb1_be",    32'(mem_be), 32'b0010);
        cyc();
        mem_ready = 1'b0;
        chk("sh_sb_drained", 32'(empty), 32'd1);

        // fill with 4 SW, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 32'h10 + 32'(4*i), 32'hD000_0000 + 32'(i));
            cyc();
            chk($sformatf("fill_st_ready%0d", i), 32'(st_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_addr%0d", i),  32'(mem_addr), (32'h10 + 32'(4*i)) >> 2);
            chk($sformatf("drain_wdata%0d", i), mem_wdata,     32'hD000_0000 + 32'(i));
            chk($sformatf("drain_be%0d", i),    32'(mem_be),   32'b1111);
            cyc();
        end
        mem_ready = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);

        // full FIFO: push and pop in the same cycle -> push refused
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 32'h20 + 32'(4*i), 32'hC000_0000 + 32'(i));
            cyc();
        end
        drive(1'b1, 2'b11, 32'h0000_0040, 32'h0000_EEEE);
        chk("full_st_ready", 32'(st_ready), 32'd0);
        mem_ready = 1'b1;
        cyc();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("full_after_pop_ready", 32'(st_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("full_drain_addr%0d", i), 32'(mem_addr), (32'h20 + 32'(4*i)) >> 2);
            cyc();
        end
        mem_ready = 1'b0;
        chk("full_push_dropped", 32'(empty), 32'd1);

        // two SB into the same word
        drive(1'b1, 2'b01, 32'h0000_0100, 32'h0000_0011);
        cyc();
        drive(1'b1, 2'b01, 32'h0000_0101, 32'h0000_0022);
        cyc();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
`ifdef STORE_MERGE_EN
        chk("merge_be",    32'(mem_be),    32'b0011);
        chk("merge_lo16",  32'(mem_wdata[15:0]), 32'h2211);
        chk("merge_wdata", mem_wdata,      32'h1111_2211);
        mem_ready = 1'b1;
        cyc();
        chk("merge_single", 32'(empty), 32'd1);
`else
        chk("nomerge_be0",    32'(mem_be), 32'b0001);
        chk("nomerge_wdata0", mem_wdata,   32'h1111_1111);
        mem_ready = 1'b1;
        cyc();
        chk("nomerge_be1",    32'(mem_be), 32'b0010);
        chk("nomerge_wdata1", mem_wdata,   32'h2222_2222);
        cyc();
        chk("nomerge_empty", 32'(empty), 32'd1);
`endif
        mem_ready = 1'b0;

        // reset mid-operation with 3 entries and a pending misalign pulse
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b11, 32'h200 + 32'(4*i), 32'hB000_0000 + 32'(i));
            cyc();
        end
        drive(1'b1, 2'b11, 32'h0000_0302, 32'h0);
        cyc();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("pre_rst_misalign", 32'(misalign), 32'd1);
        chk("pre_rst_valid",    32'(mem_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(mem_valid), 32'd0);
        chk("mid_rst_empty",    32'(empty),     32'd1);
        chk("mid_rst_misalign", 32'(misalign),  32'd0);
        chk("mid_rst_be",       32'(mem_be),    32'd0);
        chk("mid_rst_ready",    32'(st_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        cyc();
        cyc();
        mem_ready = 1'b0;
        chk("post_rst_no_stale", 32'(mem_valid), 32'd0);

        // first accept right after reset release
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'b01, 32'h0000_0000, 32'h0000_007F);
        cyc();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("first_acc_valid", 32'(mem_valid), 32'd1);
        chk("first_acc_wdata", mem_wdata,      32'h7F7F_7F7F);
        chk("first_acc_be",    32'(mem_be),    32'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
